// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: LSU request lanes, shared RAM port and per-LSU load return for lsu_mem_arbiter.
// slave is the arbiter side; master is the LSU/RAM side.
interface lsu_mem_arbiter_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   logic [NUM_PORTS-1:0]        req_rd_en;
   logic [NUM_PORTS-1:0]        req_wr_en;
   logic [NUM_PORTS*ADDR_W-1:0] req_addr;
   logic [NUM_PORTS*DATA_W-1:0] req_wr_data;
   logic [NUM_PORTS*2-1:0]      req_size;
   logic                        mem_rd_en;
   logic                        mem_wr_en;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wr_data;
   logic [1:0]                  mem_size;
   logic [DATA_W-1:0]           mem_rd_data;
   logic [NUM_PORTS*DATA_W-1:0] rsp_rd_data;
   logic                        arb_stall;
   logic [31:0]                 stat_stall_cycles;
   logic [31:0]                 stat_conflicts;
   modport slave (
      input  req_rd_en, req_wr_en, req_addr, req_wr_data, req_size, mem_rd_data,
      output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_size, rsp_rd_data, arb_stall,
             stat_stall_cycles, stat_conflicts
   );
   modport master (
      output req_rd_en, req_wr_en, req_addr, req_wr_data, req_size, mem_rd_data,
      input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_size, rsp_rd_data, arb_stall,
             stat_stall_cycles, stat_conflicts
   );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin sharing of one data-RAM port among NUM_PORTS LSU slots with per-port load hold.
// LSU_ARB_STATS_EN builds saturating stall/conflict counters; otherwise stat_* are tied to 0.
module lsu_mem_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input logic              clk,
   input logic              rst,
   lsu_mem_arbiter_if.slave bus
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   typedef enum logic {IDLE, SERIAL} state_t;
   state_t               r_state;
   logic [NUM_PORTS-1:0] r_pending;
   logic [NUM_PORTS-1:0] r_gnt_rd;
   logic [PW-1:0]        r_rr_ptr;
   logic [DATA_W-1:0]    r_hold [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_req;
   logic [NUM_PORTS-1:0] w_cand;
   logic [NUM_PORTS-1:0] w_gnt;
   logic [NUM_PORTS-1:0] w_left;
   logic [PW-1:0]        w_gnt_idx;
   logic [PW-1:0]        w_scan;
   logic [PW-1:0]        w_rr_next;
   logic                 w_any;
   logic                 w_stall;

   assign w_req     = bus.req_rd_en | bus.req_wr_en;
   assign w_cand    = (r_state == SERIAL) ? r_pending : w_req;
   assign w_left    = w_cand & ~w_gnt;
   assign w_stall   = |w_left;
   assign w_rr_next = (w_gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
   assign bus.arb_stall = w_stall;

   // First candidate at or after r_rr_ptr, wrapping at NUM_PORTS.
   always_comb begin
      w_gnt     = '0;
      w_gnt_idx = '0;
      w_any     = 1'b0;
      w_scan    = r_rr_ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!w_any && w_cand[w_scan]) begin
            w_gnt[w_scan] = 1'b1;
            w_gnt_idx     = w_scan;
            w_any         = 1'b1;
         end
         w_scan = (w_scan == PW'(NUM_PORTS - 1)) ? '0 : w_scan + 1'b1;
      end
   end

   always_comb begin
      bus.mem_rd_en   = 1'b0;
      bus.mem_wr_en   = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wr_data = '0;
      bus.mem_size    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_gnt[i]) begin
            bus.mem_rd_en   = bus.req_rd_en[i];
            bus.mem_wr_en   = bus.req_wr_en[i] & ~bus.req_rd_en[i];
            bus.mem_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
            bus.mem_wr_data = bus.req_wr_data[i*DATA_W +: DATA_W];
            bus.mem_size    = bus.req_size[i*2 +: 2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_rr_ptr  <= '0;
         r_gnt_rd  <= '0;
         for (int i = 0; i < NUM_PORTS; i++) r_hold[i] <= '0;
      end else begin
         r_state   <= w_stall ? SERIAL : IDLE;
         r_pending <= w_left;
         r_rr_ptr  <= w_any ? w_rr_next : r_rr_ptr;
         r_gnt_rd  <= w_gnt & bus.req_rd_en;
         for (int i = 0; i < NUM_PORTS; i++) if (r_gnt_rd[i]) r_hold[i] <= bus.mem_rd_data;
      end
   end

   // Live RAM data in the return cycle, held copy afterwards.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rsp
      assign bus.rsp_rd_data[g*DATA_W +: DATA_W] = r_gnt_rd[g] ? bus.mem_rd_data : r_hold[g];
   end

`ifdef LSU_ARB_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_conflicts;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_conflicts    <= '0;
      end else begin
         if (w_stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
         if (r_state == IDLE && w_stall && r_conflicts != '1) r_conflicts <= r_conflicts + 1'b1;
      end
   end
   assign bus.stat_stall_cycles = r_stall_cycles;
   assign bus.stat_conflicts    = r_conflicts;
`else
   assign bus.stat_stall_cycles = '0;
   assign bus.stat_conflicts    = '0;
`endif
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: scoreboard bench for lsu_mem_arbiter against a 1-cycle-latency RAM model.
module tb_lsu_mem_arbiter;
   typedef struct packed {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic [1:0]  size;
   } exp_t;
`ifdef LSU_ARB_STATS_EN
   localparam logic [31:0] EXP_STAT = 32'd3;
`else
   localparam logic [31:0] EXP_STAT = 32'd0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   logic [31:0] ram [logic [31:0]];

   lsu_mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) bus ();
   lsu_mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'h0;
      if (bus.mem_wr_en) ram[bus.mem_addr] = bus.mem_wr_data;
   end

   function automatic logic [31:0] rsp(input int p);
      rsp = bus.rsp_rd_data[p*32 +: 32];
   endfunction

   function automatic exp_t mk(input int p, input logic [31:0] a, input logic rd, input logic [31:0] wd);
      mk.addr  = a;
      mk.rd    = rd;
      mk.wr    = ~rd;
      mk.wdata = wd;
      mk.size  = (p == 0) ? 2'b10 : 2'b01;
   endfunction

   task automatic set_req(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a0, a1, d0, d1);
      bus.req_rd_en   = rd;
      bus.req_wr_en   = wr;
      bus.req_addr    = {a1, a0};
      bus.req_wr_data = {d1, d0};
      bus.req_size    = {2'b01, 2'b10};
   endtask

   task automatic clear_req();
      bus.req_rd_en = 2'b00;
      bus.req_wr_en = 2'b00;
   endtask

   task automatic test_reset();
      set_req(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.arb_stall, bus.mem_rd_en, bus.mem_wr_en} !== 3'b000) begin
         n_fail++; $display("FAIL reset ctrl: stall/rd/wr=%b, want 000", {bus.arb_stall, bus.mem_rd_en, bus.mem_wr_en});
      end
      n_checks++;
      if (bus.rsp_rd_data !== 64'h0) begin
         n_fail++; $display("FAIL reset rsp: got %h, want 0", bus.rsp_rd_data);
      end
      n_checks++;
      if ({bus.stat_stall_cycles, bus.stat_conflicts} !== 64'h0) begin
         n_fail++; $display("FAIL reset stats: got %h/%h, want 0/0", bus.stat_stall_cycles, bus.stat_conflicts);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_req(2'b01, 2'b00, 32'h100, 32'h104, 32'h0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_size, bus.arb_stall} !== {2'b10, 32'h100, 2'b10, 1'b0}) begin
            n_fail++; $display("FAIL single p0 issue %0d: rd=%b wr=%b addr=%h sz=%b stall=%b, want 1 0 100 10 0", c, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_size, bus.arb_stall);
         end
         @(posedge clk); #1;
      end
      clear_req();
      @(negedge clk);
      n_checks++;
      if (rsp(0) !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL single rsp0: got %h, want deadbeef", rsp(0));
      end
      n_checks++;
      if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.arb_stall} !== {2'b00, 32'h0, 1'b0}) begin
         n_fail++; $display("FAIL single idle: rd=%b wr=%b addr=%h stall=%b, want 0 0 0 0", bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.arb_stall);
      end
      n_checks++;
      if (dut.r_rr_ptr !== 1'b1) begin
         n_fail++; $display("FAIL single rr_ptr: got %b, want 1", dut.r_rr_ptr);
      end
      @(posedge clk); #1;
      set_req(2'b10, 2'b00, 32'h100, 32'h104, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_rd_en, bus.mem_addr, bus.mem_size, bus.arb_stall} !== {1'b1, 32'h104, 2'b01, 1'b0}) begin
         n_fail++; $display("FAIL single p1 issue: rd=%b addr=%h sz=%b stall=%b, want 1 104 01 0", bus.mem_rd_en, bus.mem_addr, bus.mem_size, bus.arb_stall);
      end
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      n_checks++;
      if ({rsp(1), rsp(0)} !== {32'hCAFE_F00D, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL single rsp1/rsp0: got %h/%h, want cafef00d/deadbeef", rsp(1), rsp(0));
      end
      n_checks++;
      if (dut.r_rr_ptr !== 1'b0) begin
         n_fail++; $display("FAIL single rr_ptr wrap: got %b, want 0", dut.r_rr_ptr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_conflict();
      exp_t e;
      logic done = 1'b0;
      exp_q.push_back(mk(0, 32'h10, 1'b1, 32'h0));
      exp_q.push_back(mk(1, 32'h20, 1'b1, 32'h0));
      set_req(2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         e = '0;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, bus.mem_size} !== {e.rd, e.wr, e.addr, e.wdata, e.size}) begin
            n_fail++; $display("FAIL conflict grant %0d: got rd=%b wr=%b addr=%h sz=%b, want rd=%b wr=%b addr=%h sz=%b", c, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_size, e.rd, e.wr, e.addr, e.size);
         end
         n_checks++;
         if (bus.arb_stall !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL conflict stall %0d: got %b, want %b", c, bus.arb_stall, exp_q.size() != 0);
         end
         done = !bus.arb_stall;
         @(posedge clk); #1;
      end
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL conflict timeout: stall still %b, want 0", bus.arb_stall);
      end
      clear_req();
      @(negedge clk);
      n_checks++;
      if ({rsp(0), rsp(1)} !== {32'hA1A1_0010, 32'hB2B2_0020}) begin
         n_fail++; $display("FAIL conflict rsp0/rsp1: got %h/%h, want a1a10010/b2b20020", rsp(0), rsp(1));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [1:0]  mask [5];
      logic [31:0] a0 [5];
      logic [31:0] a1 [5];
      int          first [5];
      exp_t        e;
      logic        done;
      mask  = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10};
      a0    = '{32'h30, 32'h38, 32'h30, 32'h38, 32'h0};
      a1    = '{32'h34, 32'h3C, 32'h0, 32'h3C, 32'h3C};
      first = '{0, 0, 0, 1, 1};
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < 2; k++)
            if (mask[b][first[b] ^ k]) exp_q.push_back(mk(first[b] ^ k, ((first[b] ^ k) == 0) ? a0[b] : a1[b], 1'b1, 32'h0));
         set_req(mask[b], 2'b00, a0[b], a1[b], 32'h0, 32'h0);
         done = 1'b0;
         for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            e = '0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            n_checks++;
            if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_size} !== {e.rd, e.wr, e.addr, e.size}) begin
               n_fail++; $display("FAIL b2b bundle %0d grant %0d: got rd=%b addr=%h sz=%b, want rd=%b addr=%h sz=%b", b, c, bus.mem_rd_en, bus.mem_addr, bus.mem_size, e.rd, e.addr, e.size);
            end
            n_checks++;
            if (bus.arb_stall !== (exp_q.size() != 0)) begin
               n_fail++; $display("FAIL b2b bundle %0d stall %0d: got %b, want %b", b, c, bus.arb_stall, exp_q.size() != 0);
            end
            done = !bus.arb_stall;
            @(posedge clk); #1;
         end
         n_checks++;
         if (!done) begin
            n_fail++; $display("FAIL b2b bundle %0d timeout: stall still %b, want 0", b, bus.arb_stall);
         end
      end
      clear_req();
      @(negedge clk);
      n_checks++;
      if ({rsp(0), rsp(1)} !== {32'h3838_0038, 32'h3C3C_003C}) begin
         n_fail++; $display("FAIL b2b rsp0/rsp1: got %h/%h, want 38380038/3c3c003c", rsp(0), rsp(1));
      end
      n_checks++;
      if (dut.r_rr_ptr !== 1'b0) begin
         n_fail++; $display("FAIL b2b rr_ptr: got %b, want 0", dut.r_rr_ptr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      exp_t e;
      logic done = 1'b0;
      exp_q.push_back(mk(0, 32'h40, 1'b0, 32'h55));
      exp_q.push_back(mk(1, 32'h40, 1'b1, 32'h0));
      set_req(2'b10, 2'b01, 32'h40, 32'h40, 32'h55, 32'h0);
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         e = '0;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if ({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, bus.mem_size} !== {e.rd, e.wr, e.addr, e.wdata, e.size}) begin
            n_fail++; $display("FAIL store_load grant %0d: got rd=%b wr=%b addr=%h wd=%h sz=%b, want rd=%b wr=%b addr=%h wd=%h sz=%b", c, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, bus.mem_size, e.rd, e.wr, e.addr, e.wdata, e.size);
         end
         n_checks++;
         if (bus.arb_stall !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL store_load stall %0d: got %b, want %b", c, bus.arb_stall, exp_q.size() != 0);
         end
         done = !bus.arb_stall;
         @(posedge clk); #1;
      end
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL store_load timeout: stall still %b, want 0", bus.arb_stall);
      end
      clear_req();
      @(negedge clk);
      n_checks++;
      if (rsp(1) !== 32'h55) begin
         n_fail++; $display("FAIL store_load rsp1: got %h, want 00000055", rsp(1));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_serial();
      set_req(2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_rd_en, bus.mem_addr, bus.arb_stall} !== {1'b1, 32'h10, 1'b1}) begin
         n_fail++; $display("FAIL rst_serial first grant: rd=%b addr=%h stall=%b, want 1 10 1", bus.mem_rd_en, bus.mem_addr, bus.arb_stall);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      clear_req();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.arb_stall, bus.mem_rd_en, bus.mem_wr_en} !== 3'b000) begin
         n_fail++; $display("FAIL rst_serial ctrl: stall/rd/wr=%b, want 000", {bus.arb_stall, bus.mem_rd_en, bus.mem_wr_en});
      end
      n_checks++;
      if (bus.rsp_rd_data !== 64'h0) begin
         n_fail++; $display("FAIL rst_serial rsp: got %h, want 0", bus.rsp_rd_data);
      end
      n_checks++;
      if ({dut.r_pending, dut.r_rr_ptr} !== 3'b000) begin
         n_fail++; $display("FAIL rst_serial state: pending=%b rr=%b, want 00 0", dut.r_pending, dut.r_rr_ptr);
      end
      @(posedge clk); #1;
      set_req(2'b01, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_rd_en, bus.mem_addr, bus.arb_stall} !== {1'b1, 32'h10, 1'b0}) begin
         n_fail++; $display("FAIL rst_serial idle pass: rd=%b addr=%h stall=%b, want 1 10 0", bus.mem_rd_en, bus.mem_addr, bus.arb_stall);
      end
      @(posedge clk); #1;
      clear_req();
   endtask

   task automatic test_stats();
      exp_t e;
      logic done;
      for (int b = 0; b < 3; b++) begin
         exp_q.push_back(mk(1, 32'h20, 1'b1, 32'h0));
         exp_q.push_back(mk(0, 32'h10, 1'b1, 32'h0));
         set_req(2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
         done = 1'b0;
         for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            e = '0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            n_checks++;
            if ({bus.mem_rd_en, bus.mem_addr} !== {e.rd, e.addr}) begin
               n_fail++; $display("FAIL stats bundle %0d grant %0d: got rd=%b addr=%h, want rd=%b addr=%h", b, c, bus.mem_rd_en, bus.mem_addr, e.rd, e.addr);
            end
            n_checks++;
            if (bus.arb_stall !== (exp_q.size() != 0)) begin
               n_fail++; $display("FAIL stats bundle %0d stall %0d: got %b, want %b", b, c, bus.arb_stall, exp_q.size() != 0);
            end
            done = !bus.arb_stall;
            @(posedge clk); #1;
         end
         n_checks++;
         if (!done) begin
            n_fail++; $display("FAIL stats bundle %0d timeout: stall still %b, want 0", b, bus.arb_stall);
         end
      end
      clear_req();
      @(negedge clk);
      n_checks++;
      if ({rsp(0), rsp(1)} !== {32'hA1A1_0010, 32'hB2B2_0020}) begin
         n_fail++; $display("FAIL stats rsp0/rsp1: got %h/%h, want a1a10010/b2b20020", rsp(0), rsp(1));
      end
      n_checks++;
      if (bus.stat_conflicts !== EXP_STAT) begin
         n_fail++; $display("FAIL stat_conflicts: got %0d, want %0d", bus.stat_conflicts, EXP_STAT);
      end
      n_checks++;
      if (bus.stat_stall_cycles !== EXP_STAT) begin
         n_fail++; $display("FAIL stat_stall_cycles: got %0d, want %0d", bus.stat_stall_cycles, EXP_STAT);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      ram[32'h100] = 32'hDEAD_BEEF;
      ram[32'h104] = 32'hCAFE_F00D;
      ram[32'h10]  = 32'hA1A1_0010;
      ram[32'h20]  = 32'hB2B2_0020;
      ram[32'h30]  = 32'h3030_0030;
      ram[32'h34]  = 32'h3434_0034;
      ram[32'h38]  = 32'h3838_0038;
      ram[32'h3C]  = 32'h3C3C_003C;
      test_reset();
      test_single();
      test_conflict();
      test_back_to_back();
      test_store_load();
      test_reset_serial();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
